// File: rtl/issue_cdb_scheduler_if.sv
// Issue-queue handshake and CDB select bundle between the issue queues and the scheduler.
// The master side is the scheduler; the slave side is the queue/CDB logic.
interface issue_cdb_scheduler_if;
    logic       ready_int;
    logic       ready_ld_buf;
    logic       ready_mult;
    logic       ready_div;
    logic       issue_int;
    logic       issue_ld_buf;
    logic       issue_mult;
    logic       issue_div;
    logic       div_busy;
    logic       cdb_valid;
    logic [1:0] cdb_sel;

    modport master (
        input  ready_int, ready_ld_buf, ready_mult, ready_div,
        output issue_int, issue_ld_buf, issue_mult, issue_div,
        output div_busy, cdb_valid, cdb_sel
    );

    modport slave (
        output ready_int, ready_ld_buf, ready_mult, ready_div,
        input  issue_int, issue_ld_buf, issue_mult, issue_div,
        input  div_busy, cdb_valid, cdb_sel
    );
endinterface

// File: rtl/issue_cdb_scheduler.sv
// Issue-stage scheduler: grants one issue queue per cycle, reserves the CDB slot
// each fixed-latency result will use, and drives the CDB source select.
module issue_cdb_scheduler #(
    parameter int INT_LAT      = 1,
    parameter int LD_LAT       = 1,
    parameter int MULT_LAT     = 4,
    parameter int DIV_LAT      = 6,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    issue_cdb_scheduler_if.master  bus
);
    localparam int               MAX_LAT  = DIV_LAT;
    localparam int               AGE_W    = $clog2(STARVE_LIMIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(STARVE_LIMIT);
    localparam logic [3:0]       DIV_LOAD = 4'(DIV_LAT - 1);

    // Unit index doubles as the CDB select code: 0 int, 1 ld_buf, 2 mult, 3 div.
    logic             res_v  [0:MAX_LAT];
    logic [1:0]       res_id [0:MAX_LAT];
    logic [3:0]       div_cnt;
    logic [AGE_W-1:0] age [4];

    logic [3:0] rdy;
    logic [3:0] elig;
    logic [3:0] starved;
    logic [3:0] cand;
    logic [3:0] grant;

    assign rdy = {bus.ready_div, bus.ready_mult, bus.ready_ld_buf, bus.ready_int};

    always_comb begin
        elig[0] = rdy[0] && !res_v[INT_LAT];
        elig[1] = rdy[1] && !res_v[LD_LAT];
        elig[2] = rdy[2] && !res_v[MULT_LAT];
        elig[3] = rdy[3] && !res_v[DIV_LAT] && (div_cnt == 4'd0);
        for (int u = 0; u < 4; u++) begin
            starved[u] = (age[u] >= AGE_MAX);
        end
        // Starved requesters form their own tier; within a tier longest latency wins.
        cand  = (|(elig & starved)) ? (elig & starved) : elig;
        grant = 4'b0000;
        if (!reset) begin
            if (cand[3])      grant = 4'b1000;
            else if (cand[2]) grant = 4'b0100;
            else if (cand[1]) grant = 4'b0010;
            else if (cand[0]) grant = 4'b0001;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i <= MAX_LAT; i++) begin
                res_v[i]  <= 1'b0;
                res_id[i] <= 2'd0;
            end
            div_cnt <= 4'd0;
            for (int u = 0; u < 4; u++) begin
                age[u] <= '0;
            end
        end else begin
            for (int i = 0; i < MAX_LAT; i++) begin
                res_v[i]  <= res_v[i+1];
                res_id[i] <= res_id[i+1];
            end
            res_v[MAX_LAT]  <= 1'b0;
            res_id[MAX_LAT] <= 2'd0;

            // Written at L-1 so the entry reaches slot 0 exactly L cycles after issue.
            if (grant[0]) begin
                res_v[INT_LAT-1]  <= 1'b1;
                res_id[INT_LAT-1] <= 2'd0;
            end
            if (grant[1]) begin
                res_v[LD_LAT-1]  <= 1'b1;
                res_id[LD_LAT-1] <= 2'd1;
            end
            if (grant[2]) begin
                res_v[MULT_LAT-1]  <= 1'b1;
                res_id[MULT_LAT-1] <= 2'd2;
            end
            if (grant[3]) begin
                res_v[DIV_LAT-1]  <= 1'b1;
                res_id[DIV_LAT-1] <= 2'd3;
            end

            if (grant[3])
                div_cnt <= DIV_LOAD;
            else if (div_cnt != 4'd0)
                div_cnt <= div_cnt - 4'd1;

            for (int u = 0; u < 4; u++) begin
                if (grant[u] || !rdy[u])
                    age[u] <= '0;
                else if (elig[u] && (age[u] < AGE_MAX))
                    age[u] <= age[u] + 1'b1;
            end
        end
    end

    assign bus.issue_int    = grant[0];
    assign bus.issue_ld_buf = grant[1];
    assign bus.issue_mult   = grant[2];
    assign bus.issue_div    = grant[3];
    assign bus.div_busy     = (div_cnt != 4'd0);
    assign bus.cdb_valid    = res_v[0];
    assign bus.cdb_sel      = res_v[0] ? res_id[0] : 2'd0;
endmodule

// File: tb/tb_issue_cdb_scheduler.sv
// Directed bench for issue_cdb_scheduler: a per-cycle vector table plus
// hand-written streams for div throttling, int/ld_buf starvation and mult pipelining.
module tb_issue_cdb_scheduler;
    logic clk;
    logic reset;
    issue_cdb_scheduler_if bus ();

    issue_cdb_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] rdy;   // {div, mult, ld_buf, int}
        logic [7:0] expv;  // {issue div,mult,ld,int, cdb_valid, cdb_sel[1:0], div_busy}
    } vec_t;

    vec_t tbl[$];
    int   n_checks;
    int   n_fail;

    task automatic add(input logic rst, input logic [3:0] rdy, input logic [3:0] iss,
                       input logic cv, input logic [1:0] sel, input logic busy);
        vec_t v;
        v.rst  = rst;
        v.rdy  = rdy;
        v.expv = {iss, cv, sel, busy};
        tbl.push_back(v);
    endtask

    // Drive one cycle of inputs, sample outputs mid-cycle, then advance past the edge.
    task automatic step(input logic rst, input logic [3:0] rdy, output logic [7:0] act);
        reset            = rst;
        bus.ready_int    = rdy[0];
        bus.ready_ld_buf = rdy[1];
        bus.ready_mult   = rdy[2];
        bus.ready_div    = rdy[3];
        @(negedge clk);
        act = {bus.issue_div, bus.issue_mult, bus.issue_ld_buf, bus.issue_int,
               bus.cdb_valid, bus.cdb_sel, bus.div_busy};
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx, input logic [7:0] act,
                         input logic [7:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s[%0d]: got iss=%b cv=%b sel=%0d busy=%b, want iss=%b cv=%b sel=%0d busy=%b",
                     name, idx, act[7:4], act[3], act[2:1], act[0],
                     expv[7:4], expv[3], expv[2:1], expv[0]);
        end
    endtask

    initial begin
        logic [7:0] act;
        logic [7:0] want;
        n_checks = 0;
        n_fail   = 0;

        reset            = 1'b1;
        bus.ready_int    = 1'b0;
        bus.ready_ld_buf = 1'b0;
        bus.ready_mult   = 1'b0;
        bus.ready_div    = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // reset held: grants suppressed even with all queues ready
        add(1, 4'b1111, 4'b0000, 0, 0, 0);
        // single mult returns four cycles later
        add(0, 4'b0100, 4'b0100, 0, 0, 0);
        add(0, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b0000, 4'b0000, 1, 2, 0);
        add(0, 4'b0000, 4'b0000, 0, 0, 0);
        // mult reservation blocks int targeting the same slot
        add(0, 4'b0100, 4'b0100, 0, 0, 0);
        add(0, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b0001, 4'b0000, 0, 0, 0);
        add(0, 4'b0001, 4'b0001, 1, 2, 0);
        add(0, 4'b0000, 4'b0000, 1, 0, 0);
        add(0, 4'b0000, 4'b0000, 0, 0, 0);
        // int vs ld_buf: ld_buf wins by base order
        add(0, 4'b0011, 4'b0010, 0, 0, 0);
        add(0, 4'b0000, 4'b0000, 1, 1, 0);
        // div, then reset mid-flight discards it
        add(0, 4'b1000, 4'b1000, 0, 0, 0);
        add(0, 4'b0000, 4'b0000, 0, 0, 1);
        add(0, 4'b0000, 4'b0000, 0, 0, 1);
        add(1, 4'b1000, 4'b0000, 0, 0, 1);
        add(0, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b1000, 4'b1000, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 4'b0000, 4'b0000, 0, 0, 1);
        add(0, 4'b0000, 4'b0000, 1, 3, 0);
        // div then mults: the one aimed at the div's slot is held off
        add(0, 4'b1000, 4'b1000, 0, 0, 0);
        add(0, 4'b0100, 4'b0100, 0, 0, 1);
        add(0, 4'b0100, 4'b0000, 0, 0, 1);
        add(0, 4'b0100, 4'b0100, 0, 0, 1);
        add(0, 4'b0000, 4'b0000, 0, 0, 1);
        add(0, 4'b0000, 4'b0000, 1, 2, 1);
        add(0, 4'b0000, 4'b0000, 1, 3, 0);
        add(0, 4'b0000, 4'b0000, 1, 2, 0);
        add(0, 4'b0000, 4'b0000, 0, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].rdy, act);
            check("vec", i, act, tbl[i].expv);
        end

        // div held ready: one issue every DIV_LAT cycles
        step(1'b1, 4'b0000, act);
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 4'b1000, act);
            want[7:4] = (k % 6 == 0) ? 4'b1000 : 4'b0000;
            want[3]   = (k >= 6) && (k % 6 == 0);
            want[2:1] = want[3] ? 2'd3 : 2'd0;
            want[0]   = (k % 6 != 0);
            check("div_stream", k, act, want);
        end

        // int and ld_buf held ready: int wins once every STARVE_LIMIT+1 cycles
        step(1'b1, 4'b0000, act);
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 4'b0011, act);
            want[7:4] = (k % 5 == 4) ? 4'b0001 : 4'b0010;
            want[3]   = (k >= 1);
            want[2:1] = (k >= 1 && ((k - 1) % 5 != 4)) ? 2'd1 : 2'd0;
            want[0]   = 1'b0;
            check("int_ld_starve", k, act, want);
        end

        // mult every cycle: pipelined, CDB continuously owned by mult
        step(1'b1, 4'b0000, act);
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 4'b0100, act);
            want[7:4] = 4'b0100;
            want[3]   = (k >= 4);
            want[2:1] = (k >= 4) ? 2'd2 : 2'd0;
            want[0]   = 1'b0;
            check("mult_stream", k, act, want);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
